rom_fetch_unit: RTL and testbench
=================================

// Module: rom_fetch_unit
// PURPOSE
//  Requester side of the ROM read interface: owns the program counter and drives rom_addr/rom_cs/rom_re.
//  Captures the ROM's registered data word and hands it to the decoder over a valid/ready handshake.
//  Sits between the instruction ROM and the MCU decode stage; accepts jump redirects from execute.
// PARAMETERS
//  Width      16  instruction word width; must match the ROM.
//  AddrWidth  8   ROM address width; PC width.
//  ResetPc    0   PC value loaded on reset.
// PORTS
//  clk         in   1          single clock; all state on posedge clk.
//  rst_n       in   1          asynchronous, active-low reset.
//  rom_addr    out  AddrWidth  ROM address, registered.
//  rom_cs      out  1          ROM chip select, registered.
//  rom_re      out  1          ROM read strobe, registered. The ROM captures rom_addr on its rising edge.
//  rom_data    in   Width      ROM data; updated by the ROM on posedge rom_re.
//  jump_valid  in   1          redirect request, one cycle.
//  jump_addr   in   AddrWidth  redirect target.
//  halt        in   1          level; blocks new fetch issue.
//  inst        out  Width      fetched instruction.
//  inst_pc     out  AddrWidth  address that inst came from.
//  inst_valid  out  1          inst/inst_pc valid.
//  inst_ready  in   1          decoder accepts when inst_valid && inst_ready.
// BEHAVIOUR
//  Reset values: pc=ResetPc, rom_addr=ResetPc, rom_cs=0, rom_re=0, inst=0, inst_pc=0, inst_valid=0, FSM=IDLE.
//  FSM states:
//   IDLE   -> SETUP when !halt.
//   SETUP  rom_addr=pc, rom_cs=1, rom_re=0.
//   STROBE rom_cs=1, rom_re=1. The rising edge of rom_re makes the ROM latch the data word.
//          At the end of STROBE: inst<=rom_data, inst_pc<=pc, pc<=pc+1.
//   HOLD   inst_valid=1, rom_cs=0, rom_re=0. On handshake: SETUP if !halt, else IDLE.
//  Latency: SETUP in cycle N, inst_valid=1 in cycle N+2. Throughput: 1 word per 3 cycles when inst_ready=1.
//  rom_re is high for exactly 1 cycle per fetch. rom_re is 0 whenever rom_cs=0.
//  rom_addr is stable from SETUP through STROBE and never changes while rom_re=1.
//  PC arithmetic is modulo 2^AddrWidth: pc=2^AddrWidth-1 wraps to 0, with no flag.
//  inst/inst_pc hold steady while inst_valid && !inst_ready.
//  jump_valid, any state:
//   - next cycle: pc=jump_addr, FSM=SETUP (or IDLE if halt), inst_valid=0, rom_re=0.
//   - an in-flight ROM word is discarded.
//   - jump wins over a same-cycle handshake; that handshake still counts as consumed.
//  halt: does not abort SETUP/STROBE/HOLD in progress; only blocks the transition into SETUP.
//  Reset mid-fetch: all outputs return to reset values immediately (async), including rom_re=0.
//  X bits in ROM words pass through unmodified.
// CONFIGURATION
//  ROM_FETCH_PREFETCH_EN
//   defined: after capture, the FSM goes straight to SETUP for pc+1 while HOLD data waits.
//     - the next word lands in a 1-entry prefetch buffer if inst is not yet consumed,
//       else it goes directly to inst.
//     - issue stalls while the buffer is full.
//     - throughput: 1 word per 2 cycles.
//     - jump flushes the buffer and any in-flight fetch.
//   undefined: no buffer; the 3-cycle sequential behaviour above applies.
// STRUCTURE
//  Package rom_fetch_pkg:
//   - FSM state enum (IDLE, SETUP, STROBE, HOLD).
//   - fetch-word struct {inst, inst_pc}.
//   - AddrWidth/Width defaults.
//  Sub-module rom_fetch_buf: 1-entry valid/ready skid buffer, instantiated only under ROM_FETCH_PREFETCH_EN.
// TESTING
//  1 Reset, ROM[0..2]=16'h1111,16'h2222,16'h3333, inst_ready=1:
//     -> rom_addr 0,1,2 and inst 1111,2222,3333; inst_pc 0,1,2; inst_valid every 3rd cycle.
//  2 inst_ready=0 for 5 cycles while inst=16'h2222:
//     -> inst/inst_pc stable, rom_cs=0, no rom_re pulses.
//     -> with PREFETCH_EN: exactly one rom_re pulse (addr 2), then stall.
//  3 jump_valid, jump_addr=8'h40 during STROBE of addr 5:
//     -> ROM word of addr 5 never appears on inst; next rom_addr=8'h40; inst_pc=8'h40.
//  4 ResetPc=8'hFF:
//     -> fetch order FF,00,01; inst_pc wraps to 00.
//  5 halt=1 asserted in SETUP:
//     -> that fetch completes and is handed off, FSM idles, rom_cs stays 0.
//     -> halt=0 resumes at the next pc.
//  6 rst_n pulsed low while rom_re=1:
//     -> rom_re, rom_cs, inst_valid drop without a clock edge.
//     -> after release, the first fetch is at ResetPc.

Source files
------------

// File: rtl/rom_fetch_pkg.sv
// Shared types for the ROM fetch unit: FSM state encoding, the fetch-word
// layout and default widths.
package rom_fetch_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } fetch_state_t;

   // One fetched word together with the address it came from (default widths).
   typedef struct packed {
      logic [DEF_WIDTH-1:0]      inst;
      logic [DEF_ADDR_WIDTH-1:0] inst_pc;
   } fetch_word_t;

endpackage

// File: rtl/rom_fetch_unit_buf.sv
// One-entry valid/ready skid buffer placed between ROM capture and the decoder.
// Compiled only when ROM_FETCH_PREFETCH_EN is defined; the sequential fetch
// build has no use for it.
`ifdef ROM_FETCH_PREFETCH_EN
module rom_fetch_buf #(
   parameter int DataWidth = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [DataWidth-1:0] in_data,
   output logic                 space,
   output logic                 out_valid,
   output logic [DataWidth-1:0] out_data,
   input  logic                 out_ready
);

   logic                 skid_valid;
   logic [DataWidth-1:0] skid_data;
   logic                 out_valid_nxt, skid_valid_nxt;
   logic [DataWidth-1:0] out_data_nxt, skid_data_nxt;

   // Next occupancy; a new word bypasses the skid slot when the output is free.
   always_comb begin
      out_valid_nxt  = out_valid;
      out_data_nxt   = out_data;
      skid_valid_nxt = skid_valid;
      skid_data_nxt  = skid_data;
      if (flush) begin
         out_valid_nxt  = 1'b0;
         skid_valid_nxt = 1'b0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_valid_nxt  = 1'b1;
            out_data_nxt   = skid_data;
            skid_valid_nxt = in_valid;
            if (in_valid) skid_data_nxt = in_data;
         end else begin
            out_valid_nxt = in_valid;
            if (in_valid) out_data_nxt = in_data;
         end
      end else if (in_valid) begin
         skid_valid_nxt = 1'b1;
         skid_data_nxt  = in_data;
      end
      // Only one fetch is ever in flight, so an empty skid slot after this
      // edge guarantees room for the next issued word.
      space = !skid_valid_nxt;
   end

   // Buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else begin
         out_valid  <= out_valid_nxt;
         out_data   <= out_data_nxt;
         skid_valid <= skid_valid_nxt;
         skid_data  <= skid_data_nxt;
      end
   end

endmodule
`endif

// File: rtl/rom_fetch_unit.sv
// ROM fetch unit: owns the PC, sequences the ROM read strobe and hands fetched
// words to decode over valid/ready. Jumps from execute redirect the PC.
// Optional feature macro: ROM_FETCH_PREFETCH_EN (overlap the next fetch with
// the pending hand-off through a one-entry prefetch buffer).
//
// state  | meaning
// IDLE   | no fetch issued; waits for !halt (and buffer room with prefetch)
// SETUP  | rom_addr driven with pc, rom_cs=1, rom_re=0
// STROBE | rom_re=1; ROM word captured and pc advanced at the end of the cycle
// HOLD   | word presented to decode (sequential) / stalled on full buffer (prefetch)
module rom_fetch_unit
   import rom_fetch_pkg::*;
#(
   parameter int                   Width     = DEF_WIDTH,
   parameter int                   AddrWidth = DEF_ADDR_WIDTH,
   parameter logic [AddrWidth-1:0] ResetPc   = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [AddrWidth-1:0] rom_addr,
   output logic                 rom_cs,
   output logic                 rom_re,
   input  logic [Width-1:0]     rom_data,
   input  logic                 jump_valid,
   input  logic [AddrWidth-1:0] jump_addr,
   input  logic                 halt,
   output logic [Width-1:0]     inst,
   output logic [AddrWidth-1:0] inst_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready
);

   fetch_state_t         state, state_nxt;
   logic [AddrWidth-1:0] pc, pc_nxt;
   logic                 issue_ok;
   logic                 capture;

   // A word captured in the same cycle as a jump belongs to the old path.
   assign capture = (state == STROBE) && !jump_valid;

   // Next-state and next-pc; a jump overrides everything and halt only gates issue.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      unique case (state)
         IDLE:   if (issue_ok) state_nxt = SETUP;
         SETUP:  state_nxt = STROBE;
`ifdef ROM_FETCH_PREFETCH_EN
         STROBE: state_nxt = issue_ok ? SETUP : (halt ? IDLE : HOLD);
         HOLD:   state_nxt = issue_ok ? SETUP : (halt ? IDLE : HOLD);
`else
         STROBE: state_nxt = HOLD;
         HOLD:   if (inst_valid && inst_ready) state_nxt = halt ? IDLE : SETUP;
`endif
      endcase
      if (jump_valid) begin
         state_nxt = halt ? IDLE : SETUP;
         pc_nxt    = jump_addr;
      end else if (state == STROBE) begin
         pc_nxt = pc + AddrWidth'(1);
      end
   end

   // State, pc and registered ROM strobes, decoded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= ResetPc;
         rom_addr <= ResetPc;
         rom_cs   <= 1'b0;
         rom_re   <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         rom_cs <= (state_nxt == SETUP) || (state_nxt == STROBE);
         rom_re <= (state_nxt == STROBE);
         if (state_nxt == SETUP) rom_addr <= pc_nxt;
      end
   end

`ifdef ROM_FETCH_PREFETCH_EN
   logic                          buf_space;
   logic [Width+AddrWidth-1:0]    buf_word;

   rom_fetch_buf #(
      .DataWidth (Width + AddrWidth)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (jump_valid),
      .in_valid  (capture),
      .in_data   ({rom_data, pc}),
      .space     (buf_space),
      .out_valid (inst_valid),
      .out_data  (buf_word),
      .out_ready (inst_ready)
   );

   assign {inst, inst_pc} = buf_word;
   assign issue_ok        = !halt && buf_space;
`else
   assign issue_ok = !halt;

   // Output word register: loaded at the end of STROBE, cleared on hand-off or jump.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst       <= '0;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else if (jump_valid) begin
         inst_valid <= 1'b0;
      end else if (capture) begin
         inst       <= rom_data;
         inst_pc    <= pc;
         inst_valid <= 1'b1;
      end else if (inst_valid && inst_ready) begin
         inst_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit (sequential fetch build): directed scenarios plus a
// randomized run, checked against a transaction-level model of the PC stream.
module tb_rom_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jump_valid = 1'b0;
   logic [7:0]  jump_addr = 8'h00;
   logic        halt = 1'b0;
   logic        inst_ready = 1'b1;

   logic [7:0]  rom_addr, inst_pc;
   logic        rom_cs, rom_re, inst_valid;
   logic [15:0] rom_data, inst;

   logic [7:0]  rom_addr2, inst_pc2;
   logic        rom_cs2, rom_re2, inst_valid2;
   logic [15:0] rom_data2, inst2;

   logic [15:0] mem [256];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_pc = 0;

   logic        prev_re = 1'b0, prev_cs = 1'b0, prev_valid = 1'b0;
   logic        prev_ready = 1'b0, prev_jump = 1'b0;
   logic [7:0]  prev_addr = 8'h00, prev_ipc = 8'h00;
   logic [15:0] prev_inst = 16'h0000;

   int          hs_pc[$];
   int          hs_cyc[$];
   int          re_addr[$];
   int          hs2_pc[$];
   logic [15:0] hs_inst[$];

   always #5 clk = ~clk;

   rom_fetch_unit #(.Width(16), .AddrWidth(8), .ResetPc(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_re(rom_re),
      .rom_data(rom_data), .jump_valid(jump_valid), .jump_addr(jump_addr), .halt(halt),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
   );

   rom_fetch_unit #(.Width(16), .AddrWidth(8), .ResetPc(8'hFF)) dut_ff (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr2), .rom_cs(rom_cs2), .rom_re(rom_re2),
      .rom_data(rom_data2), .jump_valid(1'b0), .jump_addr(8'h00), .halt(1'b0),
      .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2), .inst_ready(1'b1)
   );

   // ROM models: latch the addressed word on the rising edge of the read strobe.
   always @(posedge rom_re)  rom_data  <= mem[rom_addr];
   always @(posedge rom_re2) rom_data2 <= mem[rom_addr2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model and protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_pc     = 0;
         prev_re    = 1'b0;
         prev_cs    = 1'b0;
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_jump  = 1'b0;
         prev_addr  = 8'h00;
      end else begin
         if (rom_re) begin
            check("re_needs_cs", rom_cs, 1);
            check("re_one_cycle", prev_re, 0);
            check("re_after_setup", prev_cs, 1);
            check("addr_stable", rom_addr, prev_addr);
            re_addr.push_back(rom_addr);
         end
         if (prev_jump) begin
            check("jump_drops_valid", inst_valid, 0);
            check("jump_drops_re", rom_re, 0);
         end else if (prev_valid && !prev_ready) begin
            check("hold_valid", inst_valid, 1);
            check("hold_inst", inst, prev_inst);
            check("hold_pc", inst_pc, prev_ipc);
         end
         if (inst_valid && inst_ready) begin
            check("hs_pc", inst_pc, exp_pc);
            check("hs_inst", inst, mem[exp_pc]);
            hs_pc.push_back(inst_pc);
            hs_inst.push_back(inst);
            hs_cyc.push_back(cyc);
            exp_pc = (exp_pc + 1) % 256;
         end
         if (jump_valid) exp_pc = jump_addr;
         prev_re    = rom_re;
         prev_cs    = rom_cs;
         prev_addr  = rom_addr;
         prev_valid = inst_valid;
         prev_ready = inst_ready;
         prev_jump  = jump_valid;
         prev_inst  = inst;
         prev_ipc   = inst_pc;
         if (inst_valid2) hs2_pc.push_back(inst_pc2);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      hs_pc.delete();
      hs_cyc.delete();
      hs_inst.delete();
      re_addr.delete();
      hs2_pc.delete();
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      jump_valid = 1'b0;
      jump_addr  = 8'h00;
      halt       = 1'b0;
      inst_ready = 1'b1;
      step(2);
      clear_logs();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!inst_valid && n < budget);
      check(tag, inst_valid, 1);
   endtask

   initial begin
      int n;
      int n_re;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1111;
      mem[1] = 16'h2222;
      mem[2] = 16'h3333;
      mem[8'h40] = ~mem[5];

      // Reset values, then sequential fetch of 0,1,2 with a 3-cycle cadence.
      rst_n = 1'b0;
      step(2);
      check("rst_rom_cs", rom_cs, 0);
      check("rst_rom_re", rom_re, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_rom_addr", rom_addr, 8'h00);
      check("rst_rom_addr_ff", rom_addr2, 8'hFF);
      clear_logs();
      rst_n = 1'b1;
      step(10);
      check("t1_re_count", re_addr.size(), 3);
      check("t1_hs_count", hs_pc.size(), 3);
      if (re_addr.size() >= 3 && hs_pc.size() >= 3) begin
         check("t1_addr0", re_addr[0], 0);
         check("t1_addr1", re_addr[1], 1);
         check("t1_addr2", re_addr[2], 2);
         check("t1_inst0", hs_inst[0], 16'h1111);
         check("t1_inst1", hs_inst[1], 16'h2222);
         check("t1_inst2", hs_inst[2], 16'h3333);
         check("t1_pc2", hs_pc[2], 2);
         check("t1_gap01", hs_cyc[1] - hs_cyc[0], 3);
         check("t1_gap12", hs_cyc[2] - hs_cyc[1], 3);
      end
      // ResetPc=FF instance ran alongside: FF, 00, 01.
      check("t4_hs_count", hs2_pc.size(), 3);
      if (hs2_pc.size() >= 3) begin
         check("t4_pc0", hs2_pc[0], 8'hFF);
         check("t4_pc1", hs2_pc[1], 8'h00);
         check("t4_pc2", hs2_pc[2], 8'h01);
      end

      // Decoder back-pressure while inst=2222.
      do_reset();
      n = 0;
      while (hs_pc.size() < 1 && n < 20) begin
         step(1);
         n++;
      end
      check("t2_first_hs", hs_pc.size(), 1);
      inst_ready = 1'b0;
      wait_valid("t2_wait_valid", 10);
      check("t2_inst", inst, 16'h2222);
      step(1);
      n_re = re_addr.size();
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("t2_inst_stable", inst, 16'h2222);
         check("t2_pc_stable", inst_pc, 1);
         check("t2_cs_low", rom_cs, 0);
      end
      check("t2_no_re", re_addr.size(), n_re);
      inst_ready = 1'b1;
      step(3);

      // Jump to 0x40 during STROBE of address 5.
      do_reset();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rom_cs && !rom_re && rom_addr == 8'h05) && n < 60);
      check("t3_reach_setup5", rom_cs && !rom_re && rom_addr == 8'h05, 1);
      step(1);
      check("t3_in_strobe5", rom_re && rom_addr == 8'h05, 1);
      jump_valid = 1'b1;
      jump_addr  = 8'h40;
      step(1);
      jump_valid = 1'b0;
      check("t3_valid_dropped", inst_valid, 0);
      check("t3_next_addr", rom_addr, 8'h40);
      wait_valid("t3_wait_valid", 10);
      check("t3_inst_pc", inst_pc, 8'h40);
      check("t3_inst", inst, mem[8'h40]);
      step(2);

      // Halt raised in SETUP of address 1.
      do_reset();
      wait_valid("t5_wait_first", 10);
      step(1);
      check("t5_setup1", rom_cs && !rom_re && rom_addr == 8'h01, 1);
      halt = 1'b1;
      step(4);
      check("t5_hs_count", hs_pc.size(), 2);
      if (hs_pc.size() >= 2) check("t5_hs_pc1", hs_pc[1], 1);
      n_re = re_addr.size();
      check("t5_re_count", n_re, 2);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("t5_cs_idle", rom_cs, 0);
      end
      check("t5_no_re", re_addr.size(), n_re);
      halt = 1'b0;
      wait_valid("t5_wait_resume", 10);
      check("t5_resume_pc", inst_pc, 8'h02);
      check("t5_resume_inst", inst, 16'h3333);
      step(2);

      // Asynchronous reset while the read strobe is high.
      do_reset();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rom_re && n < 10);
      check("t6_saw_re", rom_re, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_re", rom_re, 0);
      check("t6_async_cs", rom_cs, 0);
      check("t6_async_valid", inst_valid, 0);
      step(2);
      clear_logs();
      rst_n = 1'b1;
      n = 0;
      while (re_addr.size() < 1 && n < 10) begin
         step(1);
         n++;
      end
      check("t6_refetch", re_addr.size(), 1);
      if (re_addr.size() >= 1) check("t6_first_addr", re_addr[0], 0);

      // Randomized ready/halt/jump traffic against the model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step(1);
         inst_ready = ($urandom % 4) != 0;
         halt       = ($urandom % 8) == 0;
         jump_valid = ($urandom % 25) == 0;
         jump_addr  = 8'($urandom);
      end
      jump_valid = 1'b0;
      halt       = 1'b0;
      inst_ready = 1'b1;
      step(10);
      check("rand_progress", hs_pc.size() > 50, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
